// File: rtl/alu_reservation_station.sv
// Two-entry ALU reservation station: holds dispatched ops until both operands arrive
// (directly or via CDB snoop), then issues the oldest ready entry to the ALU.
module alu_reservation_station #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4,
  parameter int RS_TAG_W = 3,
  parameter int STN_ID0  = 4,
  parameter int STN_ID1  = 5
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                FLUSH,
  input  logic                DISP_VALID,
  input  logic [RS_TAG_W-1:0] DISP_RS,
  input  logic [3:0]          DISP_OP,
  input  logic [TAG_W-1:0]    DISP_Q1,
  input  logic [TAG_W-1:0]    DISP_Q2,
  input  logic                DISP_R1,
  input  logic                DISP_R2,
  input  logic [XLEN-1:0]     DISP_V1,
  input  logic [XLEN-1:0]     DISP_V2,
  input  logic [TAG_W-1:0]    DISP_DEST,
  input  logic                CDB_VALID,
  input  logic [TAG_W-1:0]    CDB_TAG,
  input  logic [XLEN-1:0]     CDB_DATA,
  input  logic                FU_READY,
  output logic                FU_VALID,
  output logic [3:0]          FU_OP,
  output logic [XLEN-1:0]     FU_A,
  output logic [XLEN-1:0]     FU_B,
  output logic [TAG_W-1:0]    FU_DEST,
  output logic [1:0]          BUSY
);

  localparam logic [RS_TAG_W-1:0] STN0 = RS_TAG_W'(STN_ID0);
  localparam logic [RS_TAG_W-1:0] STN1 = RS_TAG_W'(STN_ID1);

  logic [1:0]       vld;
  logic             old1;
  logic [3:0]       op   [2];
  logic [TAG_W-1:0] dest [2];
  logic [1:0]       rdy1;
  logic [1:0]       rdy2;
  logic [TAG_W-1:0] tag1 [2];
  logic [TAG_W-1:0] tag2 [2];
  logic [XLEN-1:0]  val1 [2];
  logic [XLEN-1:0]  val2 [2];

  logic [1:0]       ready;
  logic [1:0]       hit;
  logic [1:0]       free;
  logic             sel;
  logic             fire;
  logic             byp1;
  logic             byp2;

  assign ready  = vld & rdy1 & rdy2;
  assign sel    = (ready == 2'b11) ? old1 : ready[1];
  assign fire   = (|ready) && FU_READY;
  assign free   = fire ? (sel ? 2'b10 : 2'b01) : 2'b00;
  // A busy entry never accepts dispatch, even if it is being freed this edge.
  assign hit[0] = DISP_VALID && (DISP_RS == STN0) && !vld[0];
  assign hit[1] = DISP_VALID && (DISP_RS == STN1) && !vld[1];
  assign byp1   = CDB_VALID && (CDB_TAG == DISP_Q1);
  assign byp2   = CDB_VALID && (CDB_TAG == DISP_Q2);

  assign BUSY     = vld;
  assign FU_VALID = |ready;
  assign FU_OP    = FU_VALID ? op[sel]   : '0;
  assign FU_A     = FU_VALID ? val1[sel] : '0;
  assign FU_B     = FU_VALID ? val2[sel] : '0;
  assign FU_DEST  = FU_VALID ? dest[sel] : '0;

  // Occupancy and age: the only state that reset and flush touch.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld  <= '0;
      old1 <= 1'b0;
    end else if (FLUSH) begin
      vld  <= '0;
      old1 <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (free[k])
          vld[k] <= 1'b0;
        else if (hit[k])
          vld[k] <= 1'b1;
      end
      if (hit[0])
        old1 <= vld[1] && !free[1];
      else if (hit[1])
        old1 <= !(vld[0] && !free[0]);
    end
  end

  // Entry payload: written on dispatch (with CDB bypass), otherwise snooping the CDB.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (hit[k]) begin
        op[k]   <= DISP_OP;
        dest[k] <= DISP_DEST;
        tag1[k] <= DISP_Q1;
        tag2[k] <= DISP_Q2;
        rdy1[k] <= DISP_R1 || byp1;
        rdy2[k] <= DISP_R2 || byp2;
        val1[k] <= DISP_R1 ? DISP_V1 : CDB_DATA;
        val2[k] <= DISP_R2 ? DISP_V2 : CDB_DATA;
      end else begin
        if (!rdy1[k] && CDB_VALID && (tag1[k] == CDB_TAG)) begin
          rdy1[k] <= 1'b1;
          val1[k] <= CDB_DATA;
        end
        if (!rdy2[k] && CDB_VALID && (tag2[k] == CDB_TAG)) begin
          rdy2[k] <= 1'b1;
          val2[k] <= CDB_DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station; issued ops are checked against a
// scoreboard queue filled in expected issue order.
module tb_alu_reservation_station;

  logic        CLK;
  logic        RST_N;
  logic        FLUSH;
  logic        DISP_VALID;
  logic [2:0]  DISP_RS;
  logic [3:0]  DISP_OP;
  logic [3:0]  DISP_Q1;
  logic [3:0]  DISP_Q2;
  logic        DISP_R1;
  logic        DISP_R2;
  logic [31:0] DISP_V1;
  logic [31:0] DISP_V2;
  logic [3:0]  DISP_DEST;
  logic        CDB_VALID;
  logic [3:0]  CDB_TAG;
  logic [31:0] CDB_DATA;
  logic        FU_READY;
  logic        FU_VALID;
  logic [3:0]  FU_OP;
  logic [31:0] FU_A;
  logic [31:0] FU_B;
  logic [3:0]  FU_DEST;
  logic [1:0]  BUSY;

  int          n_cmp;
  int          n_err;
  int          n_iss;
  logic [71:0] sb [$];

  alu_reservation_station dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .DISP_VALID(DISP_VALID), .DISP_RS(DISP_RS), .DISP_OP(DISP_OP),
    .DISP_Q1(DISP_Q1), .DISP_Q2(DISP_Q2), .DISP_R1(DISP_R1), .DISP_R2(DISP_R2),
    .DISP_V1(DISP_V1), .DISP_V2(DISP_V2), .DISP_DEST(DISP_DEST),
    .CDB_VALID(CDB_VALID), .CDB_TAG(CDB_TAG), .CDB_DATA(CDB_DATA),
    .FU_READY(FU_READY), .FU_VALID(FU_VALID), .FU_OP(FU_OP),
    .FU_A(FU_A), .FU_B(FU_B), .FU_DEST(FU_DEST), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] dest);
    sb.push_back({op, a, b, dest});
  endtask

  // Checks any handshake about to happen at the next edge, then advances one cycle.
  task automatic tick();
    logic [71:0] got;
    if (RST_N && !FLUSH && FU_VALID && FU_READY) begin
      n_iss++;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_underflow observed=%0d expected=nonzero", sb.size());
      end
      if (sb.size() != 0) begin
        got = {FU_OP, FU_A, FU_B, FU_DEST};
        chk($sformatf("issue%0d", n_iss), got, sb.pop_front());
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    FLUSH      = 1'b0;
    DISP_VALID = 1'b0;
    DISP_RS    = 3'd0;
    DISP_OP    = 4'd0;
    DISP_Q1    = 4'd0;
    DISP_Q2    = 4'd0;
    DISP_R1    = 1'b0;
    DISP_R2    = 1'b0;
    DISP_V1    = 32'd0;
    DISP_V2    = 32'd0;
    DISP_DEST  = 4'd0;
    CDB_VALID  = 1'b0;
    CDB_TAG    = 4'd0;
    CDB_DATA   = 32'd0;
  endtask

  task automatic disp(input logic [2:0] rs, input logic [3:0] op,
                      input logic [3:0] q1, input logic r1, input logic [31:0] v1,
                      input logic [3:0] q2, input logic r2, input logic [31:0] v2,
                      input logic [3:0] dest);
    DISP_VALID = 1'b1;
    DISP_RS    = rs;
    DISP_OP    = op;
    DISP_Q1    = q1;
    DISP_R1    = r1;
    DISP_V1    = v1;
    DISP_Q2    = q2;
    DISP_R2    = r2;
    DISP_V2    = v2;
    DISP_DEST  = dest;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    CDB_VALID = 1'b1;
    CDB_TAG   = tag;
    CDB_DATA  = data;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_iss = 0;
    idle();
    FU_READY = 1'b0;

    // Reset with a competing dispatch
    RST_N = 1'b0;
    disp(3'd4, 4'd3, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1, 32'd9, 4'd2);
    tick();
    tick();
    chk("rst_busy", 72'(BUSY), 72'(0));
    chk("rst_fu_valid", 72'(FU_VALID), 72'(0));
    RST_N = 1'b1;
    idle();
    tick();
    chk("rel_busy", 72'(BUSY), 72'(0));
    chk("rel_fu_valid", 72'(FU_VALID), 72'(0));
    chk("rel_fu_op", 72'(FU_OP), 72'(0));
    chk("rel_fu_a", 72'(FU_A), 72'(0));
    chk("rel_fu_b", 72'(FU_B), 72'(0));
    chk("rel_fu_dest", 72'(FU_DEST), 72'(0));

    // Ready dispatch to entry 0
    disp(3'd4, 4'd3, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1, 32'd9, 4'd2);
    push(4'd3, 32'd7, 32'd9, 4'd2);
    tick();
    idle();
    chk("rdy_busy", 72'(BUSY), 72'(2'b01));
    chk("rdy_fu_valid", 72'(FU_VALID), 72'(1));
    chk("rdy_fu_a", 72'(FU_A), 72'(7));
    chk("rdy_fu_b", 72'(FU_B), 72'(9));
    chk("rdy_fu_dest", 72'(FU_DEST), 72'(2));
    FU_READY = 1'b1;
    tick();
    chk("rdy_freed", 72'(BUSY), 72'(0));
    chk("rdy_fu_idle", 72'(FU_VALID), 72'(0));
    FU_READY = 1'b0;

    // Same-cycle CDB bypass into entry 1
    disp(3'd5, 4'd1, 4'd6, 1'b0, 32'hdead, 4'd0, 1'b1, 32'h10, 4'd7);
    cdb(4'd6, 32'h55);
    push(4'd1, 32'h55, 32'h10, 4'd7);
    tick();
    idle();
    chk("byp_busy", 72'(BUSY), 72'(2'b10));
    chk("byp_fu_valid", 72'(FU_VALID), 72'(1));
    chk("byp_fu_a", 72'(FU_A), 72'(32'h55));
    FU_READY = 1'b1;
    tick();
    chk("byp_freed", 72'(BUSY), 72'(0));
    FU_READY = 1'b0;

    // CDB wake-up a cycle after dispatch, with a non-matching broadcast first
    disp(3'd5, 4'd2, 4'd6, 1'b0, 32'h1234, 4'd0, 1'b1, 32'd3, 4'd8);
    push(4'd2, 32'h66, 32'd3, 4'd8);
    tick();
    idle();
    cdb(4'd7, 32'h99);
    chk("wake_wait0", 72'(FU_VALID), 72'(0));
    tick();
    idle();
    chk("wake_wrong_tag", 72'(FU_VALID), 72'(0));
    cdb(4'd6, 32'h66);
    tick();
    idle();
    chk("wake_fu_valid", 72'(FU_VALID), 72'(1));
    chk("wake_fu_a", 72'(FU_A), 72'(32'h66));
    FU_READY = 1'b1;
    tick();
    FU_READY = 1'b0;

    // Younger ready entry issues ahead of an older waiting one
    disp(3'd4, 4'd4, 4'd3, 1'b0, 32'd0, 4'd0, 1'b1, 32'd1, 4'd9);
    tick();
    disp(3'd5, 4'd5, 4'd0, 1'b1, 32'h20, 4'd0, 1'b1, 32'h30, 4'd10);
    tick();
    idle();
    push(4'd5, 32'h20, 32'h30, 4'd10);
    push(4'd4, 32'h44, 32'd1, 4'd9);
    chk("age_busy", 72'(BUSY), 72'(2'b11));
    chk("age_first_dest", 72'(FU_DEST), 72'(10));
    FU_READY = 1'b1;
    tick();
    chk("age_left", 72'(BUSY), 72'(2'b01));
    chk("age_wait", 72'(FU_VALID), 72'(0));
    cdb(4'd3, 32'h44);
    tick();
    idle();
    chk("age_wake", 72'(FU_VALID), 72'(1));
    chk("age_second_dest", 72'(FU_DEST), 72'(9));
    tick();
    chk("age_done", 72'(BUSY), 72'(0));
    FU_READY = 1'b0;

    // Both ready, ALU stalled: older entry 1 must hold steady, then issue first
    disp(3'd5, 4'd6, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd11);
    tick();
    disp(3'd4, 4'd7, 4'd0, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd12);
    tick();
    idle();
    push(4'd6, 32'd1, 32'd2, 4'd11);
    push(4'd7, 32'd3, 32'd4, 4'd12);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold%0d_valid", i), 72'(FU_VALID), 72'(1));
      chk($sformatf("hold%0d_dest", i), 72'(FU_DEST), 72'(11));
      chk($sformatf("hold%0d_a", i), 72'(FU_A), 72'(1));
      tick();
    end
    FU_READY = 1'b1;
    tick();
    chk("hold_next_dest", 72'(FU_DEST), 72'(12));
    tick();
    chk("hold_done", 72'(BUSY), 72'(0));
    FU_READY = 1'b0;

    // Dispatch into a busy entry is ignored
    disp(3'd4, 4'd8, 4'd2, 1'b0, 32'd0, 4'd0, 1'b1, 32'd5, 4'd13);
    tick();
    disp(3'd4, 4'd9, 4'd0, 1'b1, 32'haa, 4'd0, 1'b1, 32'hbb, 4'd14);
    tick();
    idle();
    chk("coll_busy", 72'(BUSY), 72'(2'b01));
    chk("coll_not_ready", 72'(FU_VALID), 72'(0));
    push(4'd8, 32'h77, 32'd5, 4'd13);
    cdb(4'd2, 32'h77);
    tick();
    idle();
    chk("coll_dest", 72'(FU_DEST), 72'(13));
    FU_READY = 1'b1;
    tick();
    chk("coll_freed", 72'(BUSY), 72'(0));
    FU_READY = 1'b0;

    // An entry being freed cannot take a dispatch on the same edge
    disp(3'd4, 4'd1, 4'd0, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd1);
    push(4'd1, 32'h11, 32'h22, 4'd1);
    tick();
    disp(3'd4, 4'd2, 4'd0, 1'b1, 32'h33, 4'd0, 1'b1, 32'h44, 4'd3);
    FU_READY = 1'b1;
    tick();
    idle();
    chk("refill_busy", 72'(BUSY), 72'(0));
    chk("refill_fu_valid", 72'(FU_VALID), 72'(0));
    FU_READY = 1'b0;

    // Flush with both entries valid, a dispatch and an accepting ALU
    disp(3'd4, 4'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd1);
    tick();
    disp(3'd5, 4'd2, 4'd0, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd2);
    tick();
    idle();
    chk("fl_pre_busy", 72'(BUSY), 72'(2'b11));
    FLUSH = 1'b1;
    FU_READY = 1'b1;
    disp(3'd5, 4'd3, 4'd0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd6, 4'd3);
    tick();
    idle();
    chk("fl_busy", 72'(BUSY), 72'(0));
    chk("fl_fu_valid", 72'(FU_VALID), 72'(0));
    chk("fl_fu_dest", 72'(FU_DEST), 72'(0));
    tick();
    chk("fl_after_busy", 72'(BUSY), 72'(0));
    chk("fl_after_valid", 72'(FU_VALID), 72'(0));
    FU_READY = 1'b0;

    chk("sb_drained", 72'(sb.size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Pair of ALU reservation stations (ALU_1 / ALU_2) sitting directly downstream of the issue queue's dispatch stage.
- Accepts one dispatched task per cycle when its dest_rs code matches a station, and holds operands until they are ready.
- Snoops the common data bus (CDB) for missing operands and fires the oldest ready entry to the ALU functional unit over a valid/ready handshake.
- Drives the per-station busy bits the dispatch stage uses for RS selection.

Parameters:
- XLEN, 32, operand/result width
- TAG_W, 4, ROB/producer tag width
- RS_TAG_W, 3, width of the dest_rs station code
- STN_ID0, 4, dest_rs code selecting entry 0 (ALU_1)
- STN_ID1, 5, dest_rs code selecting entry 1 (ALU_2)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  synchronous active-low reset
- FLUSH  in  1  synchronous squash of all entries
- DISP_VALID  in  1  dispatch strobe
- DISP_RS  in  RS_TAG_W  target station code
- DISP_OP  in  4  ALU function
- DISP_Q1 / DISP_Q2  in  TAG_W  producer tags of src1 / src2
- DISP_R1 / DISP_R2  in  1  src1 / src2 value already valid
- DISP_V1 / DISP_V2  in  XLEN  src1 / src2 values (meaningful only when R=1)
- DISP_DEST  in  TAG_W  result tag
- CDB_VALID  in  1  broadcast valid
- CDB_TAG  in  TAG_W  broadcast tag
- CDB_DATA  in  XLEN  broadcast value
- FU_READY  in  1  ALU can accept this cycle
- FU_VALID  out  1  issue request
- FU_OP  out  4  issued function
- FU_A / FU_B  out  XLEN  issued operands
- FU_DEST  out  TAG_W  issued result tag
- BUSY  out  2  bit k = entry k occupied (registered)

Behaviour:
- Each entry holds: valid, op, dest, and per operand {rdy, tag, value}. Plus one age bit, old1, which is 1 when entry 1 is older.
- Reset (RST_N=0 at edge): all valid=0, old1=0. BUSY=0, FU_VALID=0, FU_OP/FU_A/FU_B/FU_DEST=0. Reset overrides FLUSH and dispatch.
- FLUSH=1 at edge: all entries cleared. Same-cycle dispatch and issue are dropped. FU_VALID must be 0 in the following cycle.

Dispatch (DISP_VALID=1, DISP_RS==STN_IDk):
- Entry k is written at the edge only if it is free (BUSY[k]=0) at that edge.
- A dispatch to a busy entry is a protocol error: ignore it and leave the entry unchanged.
- Other DISP_RS codes are ignored.
- Same-cycle bypass: if DISP_Rn=0 and CDB_VALID with CDB_TAG==DISP_Qn, capture CDB_DATA with rdy=1.
- When the other entry is valid and not being issued this edge, the new entry becomes the younger one; otherwise it is the sole (oldest) entry.

Snoop:
- Every edge, each valid entry operand with rdy=0 and tag==CDB_TAG (CDB_VALID=1) latches CDB_DATA and sets rdy=1.
- Both entries and both operands may match simultaneously; all capture.

Issue:
- An entry is ready when valid and both rdy=1.
- Selection is combinational from registered state. If both entries are ready, pick the older (old1). Otherwise pick the single ready entry.
- FU_VALID = any ready. FU_* carry the selected entry's fields, and are zero when FU_VALID=0.
- FU_VALID must not depend on FU_READY or the same-cycle CDB. Minimum latency: operands captured at edge N → FU_VALID high in cycle N+1.
- At an edge with FU_VALID&&FU_READY, the selected entry is freed.
- FU_VALID&&!FU_READY: entry and outputs are held stable.
- An entry freed at edge N may accept a new dispatch at edge N+1 (BUSY[k]=0 during cycle N+1), not at edge N.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with DISP_VALID=1 → BUSY=00, FU_VALID=0, all FU_* =0 after release.
- Ready dispatch: DISP_RS=4, R1=R2=1, V1=7, V2=9, OP=3, DEST=2 → BUSY=01 next cycle, FU_VALID=1, FU_A=7, FU_B=9, FU_DEST=2. With FU_READY=1, BUSY=00 the cycle after.
- CDB wake-up and bypass: dispatch to entry 1 with Q1=6, R1=0. Same cycle CDB_TAG=6, CDB_DATA=0x55 → captured, FU_A=0x55 next cycle. Repeat with the CDB one cycle later → FU_VALID asserts one cycle later.
- Age ordering: dispatch entry 0 waiting on tag 3, then entry 1 ready. Entry 1 issues first. Then CDB tag 3 → entry 0 issues. Separately, with both ready and FU_READY=0 for 3 cycles, the older entry holds on FU_* unchanged, then issues first.
- Busy collision: dispatch to entry 0 while BUSY[0]=1 with different DEST → entry contents unchanged; later issue shows the original DEST.
- Flush: two valid entries, FLUSH=1 together with a dispatch and FU_READY=1 → BUSY=00 and FU_VALID=0 next cycle; no entry is written.
